// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    LRESP,
    DONE,
    ERR
  } lsu_state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  f3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    case (f3_i[1:0])
      2'b00:   load_o = f3_i[2] ? {24'b0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_o = f3_i[2] ? {16'b0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    if (f3_i[1:0] == 2'b00)
      merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    else if (f3_i[1:0] == 2'b01)
      merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the core memory stage and a word-only data memory.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_r_enable,
  output logic        mem_w_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept;
  logic        req_err;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr[31:2] >= 30'(MEM_WORDS));
    req_err      = !f3_legal(req_we, req_funct3) || misaligned || out_of_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_err)                           state_d = ERR;
          else if (req_we && req_funct3 == F3_W) state_d = WR;
          else                                   state_d = RD;
        end
      end
      RD:      state_d = we_q ? MERGE : LRESP;
      MERGE:   state_d = DONE;
      WR:      state_d = DONE;
      LRESP:   state_d = IDLE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a decode of registered state only, never of req_* inputs.
  always_comb begin
    req_ready    = (state_q == IDLE);
    mem_addr     = {addr_q[31:2], 2'b00};
    mem_r_enable = (state_q == RD);
    mem_w_enable = (state_q == MERGE) || (state_q == WR);
    mem_wdata    = '0;
    resp_valid   = (state_q == LRESP) || (state_q == DONE) || (state_q == ERR);
    resp_err     = (state_q == ERR);
    resp_rdata   = '0;
    if (state_q == MERGE) mem_wdata  = merge_data;
    if (state_q == WR)    mem_wdata  = wdata_q;
    if (state_q == LRESP) resp_rdata = load_data;
  end

  lsu_align u_align (
    .word_i  (mem_rdata),
    .off_i   (addr_q[1:0]),
    .f3_i    (f3_q),
    .wdata_i (wdata_q),
    .load_o  (load_data),
    .merge_o (merge_data)
  );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a behavioural word memory.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_r_enable;
  logic        mem_w_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [4096];

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.MEM_WORDS(4096)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_r_enable (mem_r_enable),
    .mem_w_enable (mem_w_enable),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered read, read has priority, data held when not reading.
  always @(posedge clk) begin
    if (mem_r_enable) mem_rdata <= mem[mem_addr[13:2]];
    else if (mem_w_enable) mem[mem_addr[13:2]] <= mem_wdata;
  end

  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int resp_cyc, output int rd_cyc, output int wr_cyc,
                         output logic [31:0] wdata_seen, output logic [31:0] rdata,
                         output logic err);
    resp_cyc = -1; rd_cyc = -1; wr_cyc = -1;
    wdata_seen = '0; rdata = '0; err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= 10 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_r_enable && rd_cyc < 0) rd_cyc = c;
      if (mem_w_enable && wr_cyc < 0) begin wr_cyc = c; wdata_seen = mem_wdata; end
      if (resp_valid) begin resp_cyc = c; rdata = resp_rdata; err = resp_err; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({mem_r_enable, mem_w_enable, resp_valid, resp_err} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 0000",
                         {mem_r_enable, mem_w_enable, resp_valid, resp_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, resp_rdata} !== 96'b0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0", mem_addr, mem_wdata, resp_rdata);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_loads();
    int rc, rdc, wrc; logic [31:0] ws, rd; logic er;
    logic [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ads [4] = '{32'h19F, 32'h19F, 32'h19E, 32'h19C};
    logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFFFF0F, 32'h00000E0D};
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, f3s[i], ads[i], 32'h0, rc, rdc, wrc, ws, rd, er);
      checks++;
      if (rc !== 2 || rdc !== 1 || wrc !== -1 || er !== 1'b0) begin
        errors++; $display("FAIL load%0d_timing resp=%0d rd=%0d wr=%0d err=%b want 2 1 -1 0",
                           i, rc, rdc, wrc, er);
      end
      checks++;
      if (rd !== exp[i]) begin
        errors++; $display("FAIL load%0d_data got %h want %h", i, rd, exp[i]);
      end
    end
  endtask

  task automatic test_sb();
    int rc, rdc, wrc; logic [31:0] ws, rd; logic er;
    run_req(1'b1, 3'd0, 32'h191, 32'h123456AA, rc, rdc, wrc, ws, rd, er);
    checks++;
    if (rdc !== 1 || wrc !== 2 || rc !== 3 || er !== 1'b0) begin
      errors++; $display("FAIL sb_timing rd=%0d wr=%0d resp=%0d err=%b want 1 2 3 0",
                         rdc, wrc, rc, er);
    end
    checks++;
    if (ws !== 32'h0403AA01 || rd !== 32'h0) begin
      errors++; $display("FAIL sb_data wdata=%h rdata=%h want 0403aa01 0", ws, rd);
    end
    run_req(1'b0, 3'd2, 32'h190, 32'h0, rc, rdc, wrc, ws, rd, er);
    checks++;
    if (rc !== 2 || rd !== 32'h0403AA01) begin
      errors++; $display("FAIL sb_readback resp=%0d data=%h want 2 0403aa01", rc, rd);
    end
  endtask

  task automatic test_sh();
    int rc, rdc, wrc; logic [31:0] ws, rd; logic er;
    mem[100] = 32'h04030201;
    run_req(1'b1, 3'd1, 32'h192, 32'h0000BEEF, rc, rdc, wrc, ws, rd, er);
    checks++;
    if (rc !== 3 || wrc !== 2 || ws !== 32'hBEEF0201) begin
      errors++; $display("FAIL sh_merge resp=%0d wr=%0d wdata=%h want 3 2 beef0201", rc, wrc, ws);
    end
    checks++;
    if (mem[100] !== 32'hBEEF0201) begin
      errors++; $display("FAIL sh_mem got %h want beef0201", mem[100]);
    end
  endtask

  task automatic test_sw();
    int rc, rdc, wrc; logic [31:0] ws, rd; logic er;
    run_req(1'b1, 3'd2, 32'h1A0, 32'hDEADBEEF, rc, rdc, wrc, ws, rd, er);
    checks++;
    if (rdc !== -1 || wrc !== 1 || rc !== 2 || ws !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_timing rd=%0d wr=%0d resp=%0d wdata=%h want -1 1 2 deadbeef",
                         rdc, wrc, rc, ws);
    end
    run_req(1'b0, 3'd2, 32'h1A0, 32'h0, rc, rdc, wrc, ws, rd, er);
    checks++;
    if (rc !== 2 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_readback resp=%0d data=%h want 2 deadbeef", rc, rd);
    end
  endtask

  task automatic test_errors();
    int rc, rdc, wrc; logic [31:0] ws, rd; logic er;
    logic        wes [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [4] = '{3'd2, 3'd1, 3'd2, 3'd3};
    logic [31:0] ads [4] = '{32'h192, 32'h191, 32'h4000, 32'h1A0};
    for (int i = 0; i < 4; i++) begin
      run_req(wes[i], f3s[i], ads[i], 32'hCAFEF00D, rc, rdc, wrc, ws, rd, er);
      checks++;
      if (rc !== 1 || er !== 1'b1 || rd !== 32'h0 || rdc !== -1 || wrc !== -1) begin
        errors++; $display("FAIL err%0d resp=%0d err=%b rdata=%h rd=%0d wr=%0d want 1 1 0 -1 -1",
                           i, rc, er, rd, rdc, wrc);
      end
    end
  endtask

  task automatic test_reset_merge();
    int rc, rdc, wrc; logic [31:0] ws, rd; logic er;
    mem[108] = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h1B0; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_w_enable !== 1'b1) begin
      errors++; $display("FAIL rst_merge_wen_before got %b want 1", mem_w_enable);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (mem_w_enable !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_merge_drop wen=%b rv=%b want 0 0", mem_w_enable, resp_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (mem[108] !== 32'h11223344 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_merge_mem got %h rv=%b want 11223344 0", mem[108], resp_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_merge_ready got %b want 1", req_ready);
    end
    run_req(1'b0, 3'd2, 32'h1B0, 32'h0, rc, rdc, wrc, ws, rd, er);
    checks++;
    if (rc !== 2 || rd !== 32'h11223344 || er !== 1'b0) begin
      errors++; $display("FAIL rst_merge_lw resp=%0d data=%h err=%b want 2 11223344 0", rc, rd, er);
    end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int resps = 0;
    int bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h1A0; req_wdata = '0;
    for (int c = 0; c < 12; c++) begin
      if (req_valid && req_ready) accepts++;
      if (resp_valid) begin
        resps++;
        if (resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) bad++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (accepts !== 4 || resps !== 4 || bad !== 0) begin
      errors++; $display("FAIL b2b accepts=%0d resps=%0d bad=%0d want 4 4 0", accepts, resps, bad);
    end
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[103] = 32'hFF0F0E0D;
    mem[100] = 32'h04030201;
    test_reset();
    test_loads();
    test_sb();
    test_sh();
    test_sw();
    test_errors();
    test_reset_merge();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
